// File: rtl/fourdigitlock_pkg.sv
// Shared types for the four-digit lock: programmer FSM states,
// answer status codes and digit geometry.
package fourdigitlock_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NEW,
        ST_CONFIRM,
        ST_CHECK
    } state_e;

    typedef enum logic [2:0] {
        STAT_IDLE     = 3'd0,
        STAT_NEW      = 3'd1,
        STAT_CONFIRM  = 3'd2,
        STAT_SUCCESS  = 3'd3,
        STAT_MISMATCH = 3'd4,
        STAT_TIMEOUT  = 3'd5,
        STAT_DENIED   = 3'd6
    } status_e;

    // Index 0 is the first digit, stored in the top nibble.
    function automatic logic [CODE_W-1:0] set_nibble(
        input logic [CODE_W-1:0]  v,
        input logic [1:0]         idx,
        input logic [DIGIT_W-1:0] d
    );
        logic [CODE_W-1:0] r;
        r = v;
        r[(NUM_DIGITS - 1 - int'(idx)) * DIGIT_W +: DIGIT_W] = d;
        return r;
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Single-register rising edge detector for an already
// synchronised, debounced level.
module rising_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Rise
);

    logic sig_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~sig_q;

endmodule

// File: rtl/passcode_programmer.sv
// Passcode register owner: new code entered twice, committed on match.
// Optional entry timeout enabled by PASSCODE_PROG_TIMEOUT_EN.
module passcode_programmer
    import fourdigitlock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Prog_Req,
    input  logic        i_Enter,
    input  logic [3:0]  i_Digit,
    input  logic        i_Unlocked,
    output logic [15:0] o_Code,
    output logic        o_Code_Valid,
    output logic [3:0]  o_Progress,
    output logic [2:0]  o_Status
);

    logic prog_edge, enter_edge;
    logic tmo_hit, tmo_clr;

    state_e      state_q, state_d;
    status_e     status_q, status_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  prog_q, prog_d;
    logic [15:0] new_q, new_d;
    logic [15:0] cfm_q, cfm_d;
    logic [15:0] code_q, code_d;
    logic        valid_q, valid_d;

    rising_edge_detect u_prog_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Prog_Req),
        .o_Rise  (prog_edge)
    );

    rising_edge_detect u_enter_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Enter),
        .o_Rise  (enter_edge)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        idx_d    = idx_q;
        prog_d   = prog_q;
        new_d    = new_q;
        cfm_d    = cfm_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        tmo_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (prog_edge) begin
                    if (i_Unlocked) begin
                        state_d  = ST_NEW;
                        status_d = STAT_NEW;
                        idx_d    = 2'd0;
                        prog_d   = 4'd0;
                        new_d    = '0;
                        cfm_d    = '0;
                        tmo_clr  = 1'b1;
                    end else begin
                        status_d = STAT_DENIED;
                    end
                end
            end
            ST_NEW, ST_CONFIRM: begin
                if (!i_Unlocked || (tmo_hit && !enter_edge)) begin
                    state_d  = ST_IDLE;
                    status_d = i_Unlocked ? STAT_TIMEOUT : STAT_DENIED;
                    idx_d    = 2'd0;
                    prog_d   = 4'd0;
                    new_d    = '0;
                    cfm_d    = '0;
                end else if (enter_edge) begin
                    tmo_clr = 1'b1;
                    prog_d[idx_q] = 1'b1;
                    idx_d = idx_q + 2'd1;
                    if (state_q == ST_NEW) begin
                        new_d = set_nibble(new_q, idx_q, i_Digit);
                    end else begin
                        cfm_d = set_nibble(cfm_q, idx_q, i_Digit);
                    end
                    if (idx_q == 2'd3) begin
                        // Full progress stays visible during CHECK.
                        if (state_q == ST_NEW) begin
                            state_d  = ST_CONFIRM;
                            status_d = STAT_CONFIRM;
                            prog_d   = 4'd0;
                        end else begin
                            state_d  = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                prog_d  = 4'd0;
                idx_d   = 2'd0;
                if (new_q == cfm_q) begin
                    code_d   = new_q;
                    valid_d  = 1'b1;
                    status_d = STAT_SUCCESS;
                end else begin
                    status_d = STAT_MISMATCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= ST_IDLE;
            status_q <= STAT_IDLE;
            idx_q    <= 2'd0;
            prog_q   <= 4'd0;
            new_q    <= '0;
            cfm_q    <= '0;
            code_q   <= DEFAULT_CODE;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            idx_q    <= idx_d;
            prog_q   <= prog_d;
            new_q    <= new_d;
            cfm_q    <= cfm_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

`ifdef PASSCODE_PROG_TIMEOUT_EN
    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_NEW || state_q == ST_CONFIRM) && !tmo_clr) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^{TIMEOUT_CYCLES, tmo_clr};
    assign tmo_hit    = 1'b0;
`endif

    assign o_Code       = code_q;
    assign o_Code_Valid = valid_q;
    assign o_Progress   = prog_q;
    assign o_Status     = status_q;

endmodule

// File: tb/tb_passcode_programmer.sv
// Directed bench for passcode_programmer; the timeout section
// runs only when PASSCODE_PROG_TIMEOUT_EN is defined.
module tb_passcode_programmer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog;
    logic        enter;
    logic        unl;
    logic [3:0]  digit;
    logic [15:0] code;
    logic        cv;
    logic [3:0]  progress;
    logic [2:0]  status;

    int n_chk = 0;
    int n_err = 0;
    int vcnt  = 0;
    int v0;

    always #5 clk = ~clk;

    passcode_programmer #(
        .DEFAULT_CODE   (16'h1234),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Prog_Req   (prog),
        .i_Enter      (enter),
        .i_Digit      (digit),
        .i_Unlocked   (unl),
        .o_Code       (code),
        .o_Code_Valid (cv),
        .o_Progress   (progress),
        .o_Status     (status)
    );

    always @(posedge clk) begin
        if (cv === 1'b1) vcnt++;
    end

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_prog();
        @(negedge clk);
        prog = 1'b1;
        @(negedge clk);
        prog = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0;
        prog  = 1'b0;
        enter = 1'b0;
        unl   = 1'b1;
        digit = 4'd0;
        do_reset();
        check("rst_code", code, 16'h1234);
        check("rst_stat", 16'(status), 16'd0);
        check("rst_prog", 16'(progress), 16'd0);
        check("rst_cv", 16'(cv), 16'd0);

        pulse_prog();
        check("new_stat", 16'(status), 16'd1);
        check("new_prog", 16'(progress), 16'd0);
        press(4'd5); check("n1", 16'(progress), 16'h1);
        press(4'd0); check("n2", 16'(progress), 16'h3);
        press(4'd9); check("n3", 16'(progress), 16'h7);
        press(4'd2); check("n4", 16'(progress), 16'h0);
        check("cfm_stat", 16'(status), 16'd2);
        v0 = vcnt;
        press(4'd5); check("c1", 16'(progress), 16'h1);
        press(4'd0); check("c2", 16'(progress), 16'h3);
        press(4'd9); check("c3", 16'(progress), 16'h7);
        press(4'd2); check("c4", 16'(progress), 16'hf);
        check("chk_code", code, 16'h1234);
        check("chk_cv", 16'(cv), 16'd0);
        step(1);
        check("ok_code", code, 16'h5092);
        check("ok_cv", 16'(cv), 16'd1);
        check("ok_stat", 16'(status), 16'd3);
        check("ok_prog", 16'(progress), 16'd0);
        step(1);
        check("ok_cv_low", 16'(cv), 16'd0);
        step(3);
        check("ok_pulses", 16'(vcnt - v0), 16'd1);
        check("ok_hold", 16'(status), 16'd3);

        do_reset();
        v0 = vcnt;
        pulse_prog();
        press(4'd5); press(4'd0);
        pulse_prog();
        check("ign_prog", 16'(progress), 16'h3);
        check("ign_stat", 16'(status), 16'd1);
        press(4'd9); press(4'd2);
        press(4'd5); press(4'd0); press(4'd9); press(4'd3);
        step(1);
        check("mm_stat", 16'(status), 16'd4);
        check("mm_code", code, 16'h1234);
        check("mm_prog", 16'(progress), 16'd0);
        step(2);
        check("mm_pulses", 16'(vcnt - v0), 16'd0);

        unl = 1'b0;
        pulse_prog();
        check("den_stat", 16'(status), 16'd6);
        press(4'd4);
        check("den_idle", 16'(progress), 16'd0);
        unl = 1'b1;
        pulse_prog();
        check("re_stat", 16'(status), 16'd1);
        press(4'd1); press(4'd2);
        check("ab_pre", 16'(progress), 16'h3);
        unl = 1'b0;
        step(1);
        check("ab_stat", 16'(status), 16'd6);
        check("ab_prog", 16'(progress), 16'd0);
        check("ab_code", code, 16'h1234);
        unl = 1'b1;

        @(negedge clk);
        prog  = 1'b1;
        enter = 1'b1;
        digit = 4'd7;
        @(negedge clk);
        prog  = 1'b0;
        enter = 1'b0;
        check("sim_stat", 16'(status), 16'd1);
        check("sim_prog", 16'(progress), 16'd0);
        press(4'hf); press(4'h0); press(4'ha); press(4'h1);
        press(4'hf); press(4'h0); press(4'ha); press(4'h1);
        step(1);
        check("hex_code", code, 16'hf0a1);
        check("hex_stat", 16'(status), 16'd3);

        pulse_prog();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        press(4'd5);
        check("mid_stat", 16'(status), 16'd2);
        check("mid_prog", 16'(progress), 16'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_code", code, 16'h1234);
        check("ar_cv", 16'(cv), 16'd0);
        check("ar_prog", 16'(progress), 16'd0);
        check("ar_stat", 16'(status), 16'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        press(4'd6);
        check("ar_idle", 16'(progress), 16'd0);

`ifdef PASSCODE_PROG_TIMEOUT_EN
        pulse_prog();
        press(4'd1); press(4'd2);
        step(90);
        check("to_wait", 16'(status), 16'd1);
        step(20);
        check("to_stat", 16'(status), 16'd5);
        check("to_prog", 16'(progress), 16'd0);
        pulse_prog();
        press(4'd1); press(4'd2);
        step(95);
        press(4'd3);
        step(60);
        check("rs_stat", 16'(status), 16'd1);
        check("rs_prog", 16'(progress), 16'h7);
        step(50);
        check("rs_to", 16'(status), 16'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
